// File: rtl/mem_tg_axi_wdog_pkg.sv
// mem_tg_wdog_pkg: shared types and helpers for the TG2 AXI-MM watchdog stage.
//   wdog_state_t  - watchdog FSM encoding (IDLE, BUSY, TIMEOUT)
//   outst_width() - width of an outstanding-burst counter for a given depth
//   OUTST_W       - counter width for the default depth of 64
//   sat_inc()     - increment that sticks at the all-ones value of a width
package mem_tg_wdog_pkg;

    typedef enum logic [1:0] {
        WDOG_IDLE    = 2'd0,
        WDOG_BUSY    = 2'd1,
        WDOG_TIMEOUT = 2'd2
    } wdog_state_t;

    // One extra bit so the counter can hold the full depth itself.
    function automatic int unsigned outst_width(input int unsigned max_outst);
        return $clog2(max_outst) + 1;
    endfunction

    localparam int unsigned MAX_OUTST_DEF = 64;
    localparam int unsigned OUTST_W       = outst_width(MAX_OUTST_DEF);

    // Saturating increment of the low w bits of v (w <= 64).
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] lim;
        lim = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        return (v >= lim) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/mem_tg_axi_wdog_if.sv
// ofs_fim_emif_axi_mm_if: AXI-MM bundle between TG2, the watchdog stage and
// the EMIF bridge.
//   modport user - request issuer (drives AW/W/AR, accepts B/R)
//   modport emif - memory side (accepts AW/W/AR, drives B/R)
interface ofs_fim_emif_axi_mm_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int USER_W = 1
);
    logic              awvalid, awready;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic [USER_W-1:0] awuser;

    logic                wvalid, wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic [USER_W-1:0]   wuser;

    logic              bvalid, bready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic [USER_W-1:0] buser;

    logic              arvalid, arready;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic [USER_W-1:0] aruser;

    logic              rvalid, rready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic [USER_W-1:0] ruser;

    modport user (
        output awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awuser,
        input  awready,
        output wvalid, wdata, wstrb, wlast, wuser,
        input  wready,
        input  bvalid, bid, bresp, buser,
        output bready,
        output arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, aruser,
        input  arready,
        input  rvalid, rid, rdata, rresp, rlast, ruser,
        output rready
    );

    modport emif (
        input  awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awuser,
        output awready,
        input  wvalid, wdata, wstrb, wlast, wuser,
        output wready,
        output bvalid, bid, bresp, buser,
        input  bready,
        input  arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, aruser,
        output arready,
        output rvalid, rid, rdata, rresp, rlast, ruser,
        input  rready
    );
endinterface

// File: rtl/mem_tg_axi_wdog_outst_ctr.sv
// mem_tg_outst_ctr: outstanding-burst counter for one direction.
//   clk, rst_n - clock, async active-low reset
//   inc_i      - request handshake (AW or AR)
//   dec_i      - completion handshake (B, or R with rlast)
//   cnt_o      - bursts currently outstanding
//   full_o     - cnt_o has reached MAX_OUTST
//   err_o      - completion arrived with nothing outstanding (combinational)
module mem_tg_outst_ctr #(
    parameter int unsigned MAX_OUTST = 64,
    parameter int unsigned CW        = $clog2(MAX_OUTST) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] cnt_o,
    output logic          full_o,
    output logic          err_o
);
    logic [CW-1:0] cnt_q, cnt_d;

    // A completion at zero never underflows; it only raises err_o.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i) begin
            cnt_d = cnt_q + CW'(1);
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign full_o = (cnt_q == CW'(MAX_OUTST));
    assign err_o  = dec_i && (cnt_q == '0);
endmodule

// File: rtl/mem_tg_axi_wdog.sv
// mem_tg_axi_wdog: zero-latency AXI-MM pass-through between TG2 and the EMIF
// bridge that limits outstanding bursts per direction, counts completions and
// flags a hung memory through a response watchdog.
//   clk, rst_n   - EMIF user clock, async active-low reset
//   s_if         - TG2-facing side (emif modport)
//   m_if         - EMIF-bridge-facing side (user modport)
//   tmo_cycles   - watchdog limit in cycles, 0 disables it
//   clr          - pulse: clears sticky flags, done counters, TIMEOUT state
//   wr_outst / rd_outst       - outstanding write / read bursts
//   wr_done_cnt / rd_done_cnt - saturating completion counters
//   wdog_tmo / proto_err      - sticky watchdog expiry / unexpected response
//   max_wait     - longest wait seen before a response
// Build option: define MEM_TG_WDOG_MAXWAIT_EN to build the max_wait tracker;
// otherwise max_wait is tied to 0.
module mem_tg_axi_wdog
    import mem_tg_wdog_pkg::*;
#(
    parameter int unsigned MAX_OUTST = 64,
    parameter int unsigned TMO_W     = 24,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    ofs_fim_emif_axi_mm_if.emif        s_if,
    ofs_fim_emif_axi_mm_if.user        m_if,
    input  logic [TMO_W-1:0]           tmo_cycles,
    input  logic                       clr,
    output logic [$clog2(MAX_OUTST):0] wr_outst,
    output logic [$clog2(MAX_OUTST):0] rd_outst,
    output logic [CNT_W-1:0]           wr_done_cnt,
    output logic [CNT_W-1:0]           rd_done_cnt,
    output logic                       wdog_tmo,
    output logic                       proto_err,
    output logic [TMO_W-1:0]           max_wait
);
    localparam int unsigned   OUTW       = outst_width(MAX_OUTST);
    localparam logic [1:0]    ST_IDLE    = WDOG_IDLE;
    localparam logic [1:0]    ST_BUSY    = WDOG_BUSY;
    localparam logic [1:0]    ST_TIMEOUT = WDOG_TIMEOUT;

    logic             aw_hs, ar_hs, b_hs, r_hs, rl_hs;
    logic             wr_full, rd_full, wr_err, rd_err;
    logic             blk_aw, blk_ar, cnt_zero, expire;
    logic [1:0]       state_q, state_d;
    logic [TMO_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] wdone_q, wdone_d, rdone_q, rdone_d;
    logic             wdog_q, wdog_d, perr_q, perr_d;

    // Request gating: only valid/ready of AW and AR are touched.
    assign blk_aw = wr_full || (state_q == ST_TIMEOUT);
    assign blk_ar = rd_full || (state_q == ST_TIMEOUT);

    assign m_if.awvalid = s_if.awvalid & ~blk_aw;
    assign s_if.awready = m_if.awready & ~blk_aw;
    assign m_if.arvalid = s_if.arvalid & ~blk_ar;
    assign s_if.arready = m_if.arready & ~blk_ar;

    assign m_if.awid    = s_if.awid;    assign m_if.awaddr  = s_if.awaddr;
    assign m_if.awlen   = s_if.awlen;   assign m_if.awsize  = s_if.awsize;
    assign m_if.awburst = s_if.awburst; assign m_if.awlock  = s_if.awlock;
    assign m_if.awcache = s_if.awcache; assign m_if.awprot  = s_if.awprot;
    assign m_if.awuser  = s_if.awuser;
    assign m_if.arid    = s_if.arid;    assign m_if.araddr  = s_if.araddr;
    assign m_if.arlen   = s_if.arlen;   assign m_if.arsize  = s_if.arsize;
    assign m_if.arburst = s_if.arburst; assign m_if.arlock  = s_if.arlock;
    assign m_if.arcache = s_if.arcache; assign m_if.arprot  = s_if.arprot;
    assign m_if.aruser  = s_if.aruser;
    assign m_if.wvalid  = s_if.wvalid;  assign s_if.wready  = m_if.wready;
    assign m_if.wdata   = s_if.wdata;   assign m_if.wstrb   = s_if.wstrb;
    assign m_if.wlast   = s_if.wlast;   assign m_if.wuser   = s_if.wuser;
    assign s_if.bvalid  = m_if.bvalid;  assign m_if.bready  = s_if.bready;
    assign s_if.bid     = m_if.bid;     assign s_if.bresp   = m_if.bresp;
    assign s_if.buser   = m_if.buser;
    assign s_if.rvalid  = m_if.rvalid;  assign m_if.rready  = s_if.rready;
    assign s_if.rid     = m_if.rid;     assign s_if.rdata   = m_if.rdata;
    assign s_if.rresp   = m_if.rresp;   assign s_if.rlast   = m_if.rlast;
    assign s_if.ruser   = m_if.ruser;

    assign aw_hs = m_if.awvalid & m_if.awready;
    assign ar_hs = m_if.arvalid & m_if.arready;
    assign b_hs  = m_if.bvalid & s_if.bready;
    assign r_hs  = m_if.rvalid & s_if.rready;
    assign rl_hs = r_hs & m_if.rlast;

    mem_tg_outst_ctr #(.MAX_OUTST(MAX_OUTST), .CW(OUTW)) u_wr_ctr (
        .clk(clk), .rst_n(rst_n), .inc_i(aw_hs), .dec_i(b_hs),
        .cnt_o(wr_outst), .full_o(wr_full), .err_o(wr_err)
    );

    mem_tg_outst_ctr #(.MAX_OUTST(MAX_OUTST), .CW(OUTW)) u_rd_ctr (
        .clk(clk), .rst_n(rst_n), .inc_i(ar_hs), .dec_i(rl_hs),
        .cnt_o(rd_outst), .full_o(rd_full), .err_o(rd_err)
    );

    assign cnt_zero = (wr_outst == '0) && (rd_outst == '0);
    // Equality compare: lowering tmo_cycles below the running timer does not
    // fire until the timer has been cleared and climbs again.
    assign expire   = (tmo_cycles != '0) && (tmr_q == tmo_cycles);

    always_comb begin
        tmr_d = TMO_W'(sat_inc(64'(tmr_q), TMO_W));
        if (clr || b_hs || r_hs || cnt_zero) begin
            tmr_d = '0;
        end

        wdone_d = b_hs  ? CNT_W'(sat_inc(64'(wdone_q), CNT_W)) : wdone_q;
        rdone_d = rl_hs ? CNT_W'(sat_inc(64'(rdone_q), CNT_W)) : rdone_q;
        perr_d  = perr_q | wr_err | rd_err;
        wdog_d  = wdog_q;
        state_d = state_q;

        case (state_q)
            ST_IDLE: begin
                if (!cnt_zero) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end else if (expire && !clr) begin
                    state_d = ST_TIMEOUT;
                    wdog_d  = 1'b1;
                end
            end
            ST_TIMEOUT: begin
                if (clr) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (clr) begin
            wdone_d = '0;
            rdone_d = '0;
            perr_d  = 1'b0;
            wdog_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            wdone_q <= '0;
            rdone_q <= '0;
            wdog_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            wdone_q <= wdone_d;
            rdone_q <= rdone_d;
            wdog_q  <= wdog_d;
            perr_q  <= perr_d;
        end
    end

    assign wr_done_cnt = wdone_q;
    assign rd_done_cnt = rdone_q;
    assign wdog_tmo    = wdog_q;
    assign proto_err   = perr_q;

`ifdef MEM_TG_WDOG_MAXWAIT_EN
    // tmr_q at a response handshake is the wait that response just ended.
    logic [TMO_W-1:0] maxw_q, maxw_d;

    always_comb begin
        maxw_d = maxw_q;
        if (clr) begin
            maxw_d = '0;
        end else if ((b_hs || r_hs) && (tmr_q > maxw_q)) begin
            maxw_d = tmr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            maxw_q <= '0;
        end else begin
            maxw_q <= maxw_d;
        end
    end

    assign max_wait = maxw_q;
`else
    assign max_wait = '0;
`endif
endmodule
